// File: rtl/heq_pkg.sv
// Shared types and helpers for the histogram-equalization frame controller.
package heq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HIST  = 3'd2,
    ST_CDF   = 3'd3,
    ST_APPLY = 3'd4,
    ST_DRAIN = 3'd5
  } heq_state_e;

  function automatic int unsigned heq_nbins(input int unsigned pix_w);
    return 32'd1 << pix_w;
  endfunction

endpackage

// File: rtl/heq_valid_pipe.sv
// Valid/last shift register tracking beats through the remap datapath.
module heq_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic flush,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] v_q, l_q;
  logic [DEPTH-1:0] v_nxt, l_nxt;

  generate
    if (DEPTH == 1) begin : g_one
      always_comb begin
        v_nxt = in_valid;
        l_nxt = in_valid & in_last;
      end
    end else begin : g_many
      always_comb begin
        v_nxt = {v_q[DEPTH-2:0], in_valid};
        l_nxt = {l_q[DEPTH-2:0], in_valid & in_last};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
    end else if (flush) begin
      v_q <= '0;
      l_q <= '0;
    end else if (en) begin
      v_q <= v_nxt;
      l_q <= l_nxt;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_last  = l_q[DEPTH-1];

endmodule

// File: rtl/heq_frame_controller.sv
// Sequences clear / histogram / CDF build / remap over AXI-Stream frames.
module heq_frame_controller
  import heq_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned REMAP_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] total_pixels,
  input  logic             reuse_lut,
  input  logic             continuous,
  input  logic             abort,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic             m_axis_tready,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             hist_clear,
  output logic             hist_en,
  output logic             cdf_en,
  output logic             remap_en,
  output logic             pipe_en,
  output logic [PIX_W-1:0] bin_addr,
  output logic             busy,
  output logic             lut_valid,
  output logic             frame_done,
  output logic             err_tlast_early,
  output logic             err_tlast_missing
);

  localparam int unsigned NBINS = heq_nbins(PIX_W);
  localparam logic [PIX_W-1:0] BIN_MAX = PIX_W'(NBINS - 1);

  heq_state_e       state_q, state_d;
  logic [PIX_W-1:0] bin_q;
  logic [CNT_W-1:0] beat_q, total_q;
  logic             reuse_q, lut_valid_q, err_e_q, err_m_q, done_q;
  logic             final_beat, acc, start_ok, last_hs, pipe_in_valid;

  assign final_beat = (beat_q == total_q - CNT_W'(1));

  always_comb begin
    s_axis_tready = (state_q == ST_HIST) || ((state_q == ST_APPLY) && m_axis_tready);
    pipe_en       = ((state_q == ST_APPLY) || (state_q == ST_DRAIN)) && m_axis_tready;
    hist_clear    = (state_q == ST_CLEAR);
    hist_en       = (state_q == ST_HIST) && s_axis_tvalid;
    cdf_en        = (state_q == ST_CDF);
    remap_en      = (state_q == ST_APPLY);
    busy          = (state_q != ST_IDLE);
    acc           = s_axis_tvalid && s_axis_tready;
    pipe_in_valid = (state_q == ST_APPLY) && acc;
    start_ok      = (state_q == ST_IDLE) && start && (total_pixels != '0);
    last_hs       = (state_q == ST_DRAIN) && m_axis_tvalid && m_axis_tlast && m_axis_tready;
    state_d       = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = (reuse_lut && lut_valid_q) ? ST_APPLY : ST_CLEAR;
      ST_CLEAR: if (bin_q == BIN_MAX) state_d = ST_HIST;
      ST_HIST:  if (acc && final_beat) state_d = ST_CDF;
      ST_CDF:   if (bin_q == BIN_MAX) state_d = ST_APPLY;
      ST_APPLY: if (acc && final_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_d = continuous ? (reuse_q ? ST_APPLY : ST_HIST) : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      beat_q      <= '0;
      total_q     <= '0;
      reuse_q     <= 1'b0;
      lut_valid_q <= 1'b0;
      err_e_q     <= 1'b0;
      err_m_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs && !abort;
      if (abort) begin
        beat_q <= '0;
        bin_q  <= '0;
        if ((state_q == ST_CLEAR) || (state_q == ST_HIST) || (state_q == ST_CDF))
          lut_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_ok) begin
            total_q <= total_pixels;
            reuse_q <= reuse_lut;
            err_e_q <= 1'b0;
            err_m_q <= 1'b0;
            beat_q  <= '0;
            bin_q   <= '0;
          end
          ST_CLEAR: begin
            lut_valid_q <= 1'b0;
            bin_q       <= bin_q + PIX_W'(1);
          end
          ST_CDF: begin
            bin_q <= bin_q + PIX_W'(1);
            if (bin_q == BIN_MAX) lut_valid_q <= 1'b1;
          end
          ST_HIST, ST_APPLY: if (acc) begin
            beat_q <= final_beat ? '0 : beat_q + CNT_W'(1);
            if (s_axis_tlast && !final_beat) err_e_q <= 1'b1;
            if (final_beat && !s_axis_tlast) err_m_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  heq_valid_pipe #(.DEPTH(REMAP_LAT)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (pipe_en),
    .flush     (abort),
    .in_valid  (pipe_in_valid),
    .in_last   (final_beat),
    .out_valid (m_axis_tvalid),
    .out_last  (m_axis_tlast)
  );

  assign bin_addr          = bin_q;
  assign lut_valid         = lut_valid_q;
  assign frame_done        = done_q;
  assign err_tlast_early   = err_e_q;
  assign err_tlast_missing = err_m_q;

endmodule

// File: tb/tb_heq_frame_controller.sv
// Scoreboard bench for heq_frame_controller.
module tb_heq_frame_controller;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LAT   = 3;
  localparam int unsigned NB    = 256;

  logic             clk = 1'b0;
  logic             reset, start, reuse_lut, continuous, abort;
  logic [CNT_W-1:0] total_pixels;
  logic             s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tvalid, m_axis_tlast;
  logic             hist_clear, hist_en, cdf_en, remap_en, pipe_en;
  logic [PIX_W-1:0] bin_addr;
  logic             busy, lut_valid, frame_done, err_tlast_early, err_tlast_missing;

  heq_frame_controller #(.PIX_W(PIX_W), .CNT_W(CNT_W), .REMAP_LAT(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .total_pixels      (total_pixels),
    .reuse_lut         (reuse_lut),
    .continuous        (continuous),
    .abort             (abort),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .hist_clear        (hist_clear),
    .hist_en           (hist_en),
    .cdf_en            (cdf_en),
    .remap_en          (remap_en),
    .pipe_en           (pipe_en),
    .bin_addr          (bin_addr),
    .busy              (busy),
    .lut_valid         (lut_valid),
    .frame_done        (frame_done),
    .err_tlast_early   (err_tlast_early),
    .err_tlast_missing (err_tlast_missing)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_clear, n_hist, n_cdf, n_done, n_out, n_last;
  int src_idx, tot, tlast_pos;
  bit rnd_rdy = 1'b0;
  bit stalled_prev = 1'b0;
  bit prev_last = 1'b0;
  bit exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (hist_clear) n_clear++;
      if (hist_en)    n_hist++;
      if (cdf_en)     n_cdf++;
      if (frame_done) n_done++;
      if (s_axis_tvalid && s_axis_tready) begin
        if (remap_en) exp_q.push_back(src_idx == tot - 1);
        src_idx = (src_idx == tot - 1) ? 0 : src_idx + 1;
      end
      if (stalled_prev) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (m_axis_tlast) n_last++;
        if (exp_q.size() == 0) check("sb_unexpected_beat", 1, 0);
        else check("sb_tlast", m_axis_tlast, exp_q.pop_front());
      end
      stalled_prev = m_axis_tvalid && !m_axis_tready;
      prev_last    = m_axis_tlast;
    end
  end

  always @(posedge clk) begin
    #1;
    s_axis_tlast  = (src_idx == tlast_pos);
    m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic clear_counts();
    n_clear = 0; n_hist = 0; n_cdf = 0; n_done = 0; n_out = 0; n_last = 0;
  endtask

  task automatic do_start(input int total, input bit reuse, input int tl);
    @(posedge clk); #1;
    tot = total; src_idx = 0; tlast_pos = tl;
    total_pixels = CNT_W'(total);
    reuse_lut = reuse;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("frame_done_timeout", n_done >= target, 1);
  endtask

  initial begin
    int c0, k;
    reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    reuse_lut = 1'b0; total_pixels = '0; s_axis_tvalid = 1'b1;
    tot = 16; tlast_pos = 15; src_idx = 0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_lut_valid", lut_valid, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_errs", {err_tlast_early, err_tlast_missing}, 0);
    reset = 1'b0;

    // full frame, sink always ready
    clear_counts();
    do_start(16, 0, 15);
    check("t1_clear_entry", hist_clear, 1);
    check("t1_bin0", bin_addr, 0);
    wait_done(1, 3000);
    #1;
    check("t1_clear_cycles", n_clear, NB);
    check("t1_hist_en", n_hist, 16);
    check("t1_cdf_cycles", n_cdf, NB);
    check("t1_outputs", n_out, 16);
    check("t1_tlast_count", n_last, 1);
    check("t1_idle", busy, 0);
    check("t1_lut_valid", lut_valid, 1);
    check("t1_errs", {err_tlast_early, err_tlast_missing}, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // LUT reuse with random sink backpressure
    rnd_rdy = 1'b1;
    clear_counts();
    do_start(16, 1, 15);
    check("t2_apply_direct", remap_en, 1);
    wait_done(1, 3000);
    #1;
    rnd_rdy = 1'b0;
    check("t2_no_clear", n_clear, 0);
    check("t2_no_cdf", n_cdf, 0);
    check("t2_no_hist", n_hist, 0);
    check("t2_outputs", n_out, 16);
    check("t2_tlast_count", n_last, 1);
    check("t2_sb_empty", exp_q.size(), 0);

    // early tlast on beat 5, missing on beat 16
    clear_counts();
    do_start(16, 1, 4);
    wait_done(1, 3000);
    #1;
    check("t3_err_early", err_tlast_early, 1);
    check("t3_err_missing", err_tlast_missing, 1);
    check("t3_outputs", n_out, 16);
    check("t3_tlast_count", n_last, 1);

    // abort mid-histogram
    clear_counts();
    do_start(16, 0, 15);
    k = 0;
    while (n_hist < 5 && k < 1000) begin @(posedge clk); k++; end
    check("t4_reach_hist", n_hist >= 5, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_lut_invalid", lut_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_done", n_done, 0);
    check("t4_no_output", n_out, 0);

    // zero-length start is ignored
    clear_counts();
    do_start(0, 0, -1);
    check("t5_ignored", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_clear", n_clear, 0);

    // continuous over two frames
    clear_counts();
    continuous = 1'b1;
    do_start(16, 0, 15);
    wait_done(1, 3000);
    #1 continuous = 1'b0;
    check("t6_still_busy", busy, 1);
    c0 = n_clear;
    wait_done(2, 3000);
    #1;
    check("t6_no_second_clear", n_clear - c0, 0);
    check("t6_hist_en", n_hist, 32);
    check("t6_outputs", n_out, 32);
    check("t6_tlast_count", n_last, 2);
    check("t6_idle", busy, 0);
    check("t6_lut_valid", lut_valid, 1);

    // reset mid-apply
    clear_counts();
    do_start(16, 1, 15);
    k = 0;
    while (n_out < 3 && k < 1000) begin @(posedge clk); k++; end
    check("t7_reach_apply", n_out >= 3, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t7_m_tvalid", m_axis_tvalid, 0);
    check("t7_busy", busy, 0);
    check("t7_lut_valid", lut_valid, 0);
    check("t7_remap_en", remap_en, 0);
    check("t7_s_tready", s_axis_tready, 0);
    check("t7_pipe_en", pipe_en, 0);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
